// File: rtl/acc_alu_core.sv
// acc_alu_core: bank of NUM_ACC accumulators driven by a valid/ready command
// stream, producing one result beat (value + flags) per accepted command.
// Optional feature macro: ACC_ALU_MUL_EN adds a WIDTH-cycle shift-add MUL (0x0B);
// without it 0x0B is decoded as an illegal opcode.
module acc_alu_core #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_ACC   = 4,
    localparam int unsigned ACC_SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           op,
    input  logic [ACC_SEL_W-1:0] acc_sel,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     data_out,
    output logic                 zero,
    output logic                 carry,
    output logic                 neg,
    output logic                 err
);

`ifdef ACC_ALU_MUL_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StOut = 2'd1, StMult = 2'd2} state_e;
    localparam int unsigned CntW = $clog2(WIDTH);
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StOut = 2'd1} state_e;
`endif

    state_e           state_q;
    logic [WIDTH-1:0] acc_q [NUM_ACC];
    logic [WIDTH-1:0] data_q;
    logic             zero_q;
    logic             carry_q;
    logic             neg_q;
    logic             err_q;

    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;
    logic             alu_err;
    logic             accept;

`ifdef ACC_ALU_MUL_EN
    logic                 is_mul;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [CntW-1:0]      cnt_q;
    logic [ACC_SEL_W-1:0] msel_q;
    logic [2*WIDTH-1:0]   prod_nxt;
    logic                 mul_last;

    // One partial product per cycle, consuming the multiplier LSB-first.
    always_comb begin
        prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
        mul_last = (cnt_q == CntW'(WIDTH - 1));
    end
`endif

    // Handshake: ready in IDLE, or in OUT when the current beat is being taken.
    always_comb begin
        in_ready  = rst && ((state_q == StIdle) || ((state_q == StOut) && out_ready));
        out_valid = (state_q == StOut);
        accept    = in_valid && in_ready;
        data_out  = data_q;
        zero      = zero_q;
        carry     = carry_q;
        neg       = neg_q;
        err       = err_q;
    end

    // Single-cycle ALU on the currently selected accumulator; illegal ops keep A.
    always_comb begin
        a_sel   = acc_q[acc_sel];
        alu_res = a_sel;
        alu_cy  = 1'b0;
        alu_err = 1'b0;
`ifdef ACC_ALU_MUL_EN
        is_mul  = 1'b0;
`endif
        case (op)
            8'h00, 8'h09: alu_res = a_sel;
            8'h01: alu_res = data_in;
            8'h02: {alu_cy, alu_res} = {1'b0, a_sel} + {1'b0, data_in};
            8'h03: begin
                alu_res = a_sel - data_in;
                alu_cy  = (a_sel < data_in);
            end
            8'h04: alu_res = a_sel & data_in;
            8'h05: alu_res = a_sel | data_in;
            8'h06: alu_res = a_sel ^ data_in;
            8'h07: begin
                alu_res = {a_sel[WIDTH-2:0], 1'b0};
                alu_cy  = a_sel[WIDTH-1];
            end
            8'h08: begin
                alu_res = {1'b0, a_sel[WIDTH-1:1]};
                alu_cy  = a_sel[0];
            end
            8'h0A: alu_res = '0;
`ifdef ACC_ALU_MUL_EN
            8'h0B: is_mul = 1'b1;
`endif
            default: alu_err = 1'b1;
        endcase
    end

    // Control FSM, accumulator bank and registered result beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef ACC_ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            msel_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StOut: begin
                    if (accept) begin
`ifdef ACC_ALU_MUL_EN
                        if (is_mul) begin
                            mcand_q  <= {{WIDTH{1'b0}}, a_sel};
                            mplier_q <= data_in;
                            prod_q   <= '0;
                            cnt_q    <= '0;
                            msel_q   <= acc_sel;
                            state_q  <= StMult;
                        end else
`endif
                        begin
                            // Writing A at accept lets a dependent next command see it.
                            acc_q[acc_sel] <= alu_res;
                            data_q         <= alu_res;
                            zero_q         <= (alu_res == '0);
                            neg_q          <= alu_res[WIDTH-1];
                            carry_q        <= alu_cy;
                            err_q          <= alu_err;
                            state_q        <= StOut;
                        end
                    end else if ((state_q == StOut) && out_ready) begin
                        state_q <= StIdle;
                    end
                end
`ifdef ACC_ALU_MUL_EN
                StMult: begin
                    prod_q   <= prod_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (mul_last) begin
                        acc_q[msel_q] <= prod_nxt[WIDTH-1:0];
                        data_q        <= prod_nxt[WIDTH-1:0];
                        zero_q        <= (prod_nxt[WIDTH-1:0] == '0);
                        neg_q         <= prod_nxt[WIDTH-1];
                        carry_q       <= |prod_nxt[2*WIDTH-1:WIDTH];
                        err_q         <= 1'b0;
                        state_q       <= StOut;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_alu_core.sv
// Self-checking bench for acc_alu_core (WIDTH=16, NUM_ACC=4): directed scenarios
// with literal expectations plus a randomized phase, all beats scored against a
// behavioural model. Honours ACC_ALU_MUL_EN the same way the design does.
module tb_acc_alu_core;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  op = 8'h00;
    logic [1:0]  acc_sel = 2'd0;
    logic [15:0] data_in = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] data_out;
    logic        zero, carry, neg, err;

    acc_alu_core #(.WIDTH(W), .NUM_ACC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_sel   (acc_sel),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .zero      (zero),
        .carry     (carry),
        .neg       (neg),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic [3:0]  flags;  // {zero, carry, neg, err}
    } beat_t;

    beat_t       exp_q[$];
    int          macc[4];
    logic        pv, pr;
    logic [15:0] pd;
    logic [3:0]  pf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result of one command from the opcode table, independent of any hardware structure.
    function automatic beat_t model(input logic [7:0] o, input int a, input int d, input int now);
        beat_t  b;
        longint p;
        int     r   = a;
        int     c   = 0;
        int     e   = 0;
        int     lat = 1;
        case (o)
            8'h00, 8'h09: r = a;
            8'h01: r = d;
            8'h02: begin r = a + d; c = (r >> 16) & 1; end
            8'h03: begin r = a - d; c = (a < d) ? 1 : 0; end
            8'h04: r = a & d;
            8'h05: r = a | d;
            8'h06: r = a ^ d;
            8'h07: begin c = (a >> 15) & 1; r = a * 2; end
            8'h08: begin c = a & 1; r = a / 2; end
            8'h0A: r = 0;
            8'h0B: begin
`ifdef ACC_ALU_MUL_EN
                p   = longint'(a) * longint'(d);
                r   = int'(p % 65536);
                c   = ((p / 65536) != 0) ? 1 : 0;
                lat = W;
`else
                e = 1;
`endif
            end
            default: e = 1;
        endcase
        r       = r & 32'hFFFF;
        b.data  = r[15:0];
        b.flags = {(r == 0), c[0], r[15], e[0]};
        b.due   = now + lat;
        return b;
    endfunction

    // Single compare process: reset values, beat timing, backpressure stability, values.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_data_out", data_out, 0);
            chk("rst_flags", {zero, carry, neg, err}, 0);
            exp_q.delete();
            for (int i = 0; i < 4; i++) macc[i] = 0;
            pv = 1'b0;
            pr = 1'b1;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    if (pv && !pr) begin
                        chk("hold_data", data_out, pd);
                        chk("hold_flags", {zero, carry, neg, err}, pf);
                    end else begin
                        chk("latency", cyc, exp_q[0].due);
                    end
                    chk("beat_data", data_out, exp_q[0].data);
                    chk("beat_flags", {zero, carry, neg, err}, exp_q[0].flags);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                chk("missing_beat", 0, 1);
                void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                beat_t b;
                b = model(op, macc[acc_sel], int'(data_in), cyc);
                macc[acc_sel] = int'(b.data);
                exp_q.push_back(b);
            end
            pv = out_valid;
            pr = out_ready;
            pd = data_out;
            pf = {zero, carry, neg, err};
        end
    end

    task automatic send(input logic [7:0] o, input logic [1:0] s, input logic [15:0] d);
        bit ok = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; acc_sel = s; data_in = d;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_beat();
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        if (!ok) chk("beat_timeout", 0, 1);
    endtask

    task automatic expect_beat(input string nm, input logic [15:0] d, input logic [3:0] f);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_data"}, data_out, d);
        chk({nm, "_flags"}, {zero, carry, neg, err}, f);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;

        // Fresh accumulators read as zero.
        for (int s = 0; s < 4; s++) begin
            send(8'h09, 2'(s), 16'($urandom));
            wait_beat();
            expect_beat("read_init", 16'h0000, 4'b1000);
        end

        // ADD wrap with carry, neighbours untouched.
        send(8'h01, 2'd1, 16'hFFFF); wait_beat();
        send(8'h02, 2'd1, 16'h0001); wait_beat();
        expect_beat("add_wrap", 16'h0000, 4'b1100);
        send(8'h09, 2'd0, 16'h0); wait_beat(); expect_beat("acc0_clean", 16'h0000, 4'b1000);
        send(8'h09, 2'd2, 16'h0); wait_beat(); expect_beat("acc2_clean", 16'h0000, 4'b1000);
        send(8'h09, 2'd3, 16'h0); wait_beat(); expect_beat("acc3_clean", 16'h0000, 4'b1000);

        // SUB borrow then logical SHR.
        send(8'h01, 2'd2, 16'h0003); wait_beat();
        send(8'h03, 2'd2, 16'h0005); wait_beat();
        expect_beat("sub_borrow", 16'hFFFE, 4'b0110);
        send(8'h08, 2'd2, 16'h0000); wait_beat();
        expect_beat("shr", 16'h7FFF, 4'b0000);

        // Backpressure: beat held, command pending until out_ready.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h01, 2'd3, 16'h1234); wait_beat();
        expect_beat("bp_first", 16'h1234, 4'b0000);
        @(posedge clk); #1;
        in_valid = 1'b1; op = 8'h07; acc_sel = 2'd3; data_in = 16'h0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            expect_beat("bp_hold", 16'h1234, 4'b0000);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_high", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_beat();
        expect_beat("bp_next_shl", 16'h2468, 4'b0000);

        // MUL overflow (or illegal-op behaviour when the multiplier is absent).
        send(8'h01, 2'd0, 16'h0100); wait_beat();
        send(8'h0B, 2'd0, 16'h0100); wait_beat();
`ifdef ACC_ALU_MUL_EN
        expect_beat("mul_ovf", 16'h0000, 4'b1100);
        send(8'h01, 2'd0, 16'h0007); wait_beat();
        send(8'h0B, 2'd0, 16'h0003);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mul_abort_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        send(8'h09, 2'd0, 16'h0); wait_beat();
        expect_beat("mul_abort_acc0", 16'h0000, 4'b1000);
`else
        expect_beat("mul_illegal", 16'h0100, 4'b0001);
`endif

        // Illegal opcode keeps A; next legal op is normal.
        send(8'h01, 2'd2, 16'h7FFF); wait_beat();
        send(8'h3C, 2'd2, 16'h1111); wait_beat();
        expect_beat("illegal_3c", 16'h7FFF, 4'b0001);
        send(8'h02, 2'd2, 16'h0001); wait_beat();
        expect_beat("after_illegal", 16'h8000, 4'b0010);

        // Randomized traffic with random backpressure, scored by the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(posedge clk); #1;
            r         = int'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = (r < 13) ? 8'(r) : 8'($urandom_range(12, 255));
            acc_sel   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       data_in = 16'h0000;
                1:       data_in = 16'hFFFF;
                default: data_in = 16'($urandom);
            endcase
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
